// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment patterns, digit count and scanner state enum.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low gfedcba patterns; element n is the glyph for digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {LOAD, SCAN} state_t;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: BCD digit inputs and multiplexed display outputs.
interface bcd_display_scanner_if;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [6:0] segments;
    logic [3:0] anodes;
    logic       frame_tick;

    modport master (
        output digit0, digit1, digit2, digit3,
        input  segments, anodes, frame_tick
    );

    modport slave (
        input  digit0, digit1, digit2, digit3,
        output segments, anodes, frame_tick
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low gfedcba decoder, dash for 10..15.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    assign seg = (bcd > 4'd9) ? SEG_DASH : SEG_DIGIT[bcd];
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: four-digit multiplexed seven-segment driver with a per-frame shadow register.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input logic clock,
    input logic reset,
    bcd_display_scanner_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    state_t                      state, state_nxt;
    logic [15:0]                 scan_cnt, cnt_nxt;
    logic [IDX_W-1:0]            digit_idx, idx_nxt;
    logic [NUM_DIGITS-1:0][3:0]  shadow, shadow_nxt, digits_in;
    logic [NUM_DIGITS-1:0]       anodes_q, anodes_nxt;
    logic [6:0]                  seg_q, seg_nxt, seg_raw, seg_lit;
    logic                        tick_q, tick_nxt;
    logic                        wrap;

    assign digits_in = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    assign wrap      = scan_cnt == 16'(SCAN_DIV - 1);

    bcd_to_seg7 u_dec (
        .bcd (shadow[digit_idx]),
        .seg (seg_raw)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only when it and every more significant digit are zero.
    logic [NUM_DIGITS-1:0] blank;
    assign blank[3] = shadow[3] == 4'd0;
    assign blank[2] = blank[3] && shadow[2] == 4'd0;
    assign blank[1] = blank[2] && shadow[1] == 4'd0;
    assign blank[0] = 1'b0;
    assign seg_lit  = blank[digit_idx] ? SEG_BLANK : seg_raw;
`else
    assign seg_lit = seg_raw;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = scan_cnt;
        idx_nxt    = digit_idx;
        shadow_nxt = shadow;
        tick_nxt   = 1'b0;
        anodes_nxt = '1;
        seg_nxt    = SEG_BLANK;
        if (state == LOAD) begin
            shadow_nxt = digits_in;
            tick_nxt   = 1'b1;
            state_nxt  = SCAN;
            cnt_nxt    = '0;
            idx_nxt    = '0;
        end else begin
            anodes_nxt = ~(NUM_DIGITS'(1) << digit_idx);
            seg_nxt    = seg_lit;
            cnt_nxt    = wrap ? '0 : scan_cnt + 16'd1;
            idx_nxt    = wrap ? digit_idx + IDX_W'(1) : digit_idx;
            // Reload coincides with the last cycle of the final digit, so no frame tears.
            if (wrap && digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                shadow_nxt = digits_in;
                tick_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= LOAD;
            scan_cnt  <= '0;
            digit_idx <= '0;
            shadow    <= '0;
            anodes_q  <= '1;
            seg_q     <= SEG_BLANK;
            tick_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            scan_cnt  <= cnt_nxt;
            digit_idx <= idx_nxt;
            shadow    <= shadow_nxt;
            anodes_q  <= anodes_nxt;
            seg_q     <= seg_nxt;
            tick_q    <= tick_nxt;
        end
    end

    assign bus.anodes     = anodes_q;
    assign bus.segments   = seg_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed frame-by-frame checks of the display scanner at SCAN_DIV=4.
module tb_bcd_display_scanner;
    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    bcd_display_scanner_if bus ();

    bcd_display_scanner #(.SCAN_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SZ = SB;
`else
    localparam logic [6:0] SZ = S0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        bus.digit3 = d3;
        bus.digit2 = d2;
        bus.digit1 = d1;
        bus.digit0 = d0;
    endtask

    task automatic check_load;
        check("load_tick", bus.frame_tick, 1);
        check("load_anodes", bus.anodes, 4'b1111);
        check("load_segments", bus.segments, SB);
    endtask

    // One 16-cycle frame: four digits, four cycles each, tick on the final cycle.
    task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s [4];
        logic [3:0] an;
        logic [6:0] sg;
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 16; i++) begin
            step;
            an = ~(4'b0001 << (i / 4));
            sg = s[i / 4];
            check("scan_anodes", bus.anodes, an);
            check("scan_segments", bus.segments, sg);
            check("scan_tick", bus.frame_tick, i == 15);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_digits(4'd3, 4'd2, 4'd1, 4'd0);
        repeat (3) step;
        check("rst_anodes", bus.anodes, 4'b1111);
        check("rst_segments", bus.segments, SB);
        check("rst_tick", bus.frame_tick, 0);

        reset = 1'b0;
        step;
        check_load;
        fork
            begin
                @(posedge clock);
                @(posedge clock);
                #2 bus.digit0 = 4'd9;
            end
        join_none
        check_frame(S0, S1, S2, S3);
        check_frame(S9, S1, S2, S3);

        bus.digit2 = 4'hC;
        check_frame(S9, S1, S2, S3);
        check_frame(S9, S1, SD, S3);

        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        check_frame(S9, S1, SD, S3);
        check_frame(S5, SZ, SZ, SZ);

        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        check_frame(S5, SZ, SZ, SZ);
        check_frame(S0, SZ, SZ, SZ);

        set_digits(4'd3, 4'd2, 4'd1, 4'd0);
        check_frame(S0, SZ, SZ, SZ);
        repeat (10) check_frame(S0, S1, S2, S3);

        repeat (6) step;
        reset = 1'b1;
        step;
        check("midrst_anodes", bus.anodes, 4'b1111);
        check("midrst_segments", bus.segments, SB);
        check("midrst_tick", bus.frame_tick, 0);
        reset = 1'b0;
        step;
        check_load;
        check_frame(S0, S1, S2, S3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles each digit is lit; legal range 2..65535.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 digit0..digit3  input  4 each  BCD digits from the upstream 9-to-0 counter chain; digit0 is least significant.
REQ-005 segments  output  7  gfedcba cathode pattern, active-low, registered.
REQ-006 anodes  output  4  one-cold digit enable, bit n drives digit n, registered.
REQ-007 frame_tick  output  1  single-cycle pulse marking each shadow-register load.

Function
REQ-008 The state machine SHALL have states LOAD and SCAN; reset forces LOAD.
REQ-009 LOAD SHALL last exactly one cycle, capture digit0..digit3 into a shadow register, assert frame_tick, hold anodes=4'b1111, and go to SCAN with scan_cnt=0, digit_idx=0.
REQ-010 In SCAN, scan_cnt SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit_idx SHALL advance 0->1->2->3->0.
REQ-011 When scan_cnt wraps with digit_idx=3, the shadow SHALL reload from the inputs on that edge and frame_tick SHALL pulse for one cycle.
REQ-012 Input changes between reloads SHALL NOT affect outputs (no tearing within a frame).
REQ-013 anodes/segments SHALL reflect digit_idx and shadow[digit_idx] with one cycle of register latency; exactly one anode low in SCAN.
REQ-014 Decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 Non-BCD codes 10..15 SHALL display dash 0111111.
REQ-016 Each digit SHALL be lit for exactly SCAN_DIV consecutive cycles; frame period is 4*SCAN_DIV cycles.

Reset
REQ-017 While reset is high: anodes=4'b1111, segments=7'b1111111, frame_tick=0, scan_cnt=0, digit_idx=0, shadow=0.
REQ-018 Reset asserted mid-scan SHALL blank outputs on the next edge and restart via LOAD after release.

Configuration
REQ-019 Macro LEADING_ZERO_BLANK_EN defined: shadow zeros in digit3, then digit2, then digit1, preceded only by zeros, SHALL drive segments=1111111 with the anode still scanned; digit0 never blanked.
REQ-020 Macro undefined: all zeros SHALL display as 1000000; no blanking logic present.

Structure
REQ-021 Shared package seg7_pkg SHALL hold NUM_DIGITS=4, the ten digit patterns, SEG_DASH, SEG_BLANK and the state enum.
REQ-022 Sub-module bcd_to_seg7 (4-bit in, 7-bit out, combinational) SHALL implement REQ-014/015.

Verification
REQ-023 SCAN_DIV=4, inputs 3,2,1,0 (digit3..0), release reset -> cycle 1 after release frame_tick=1, anodes=1111; cycles 2-5 anodes=1110 segments=1000000; cycles 6-9 anodes=1101 segments=1111001.
REQ-024 SCAN_DIV=4, change digit0 from 0 to 9 at cycle 3 -> digit0 still shows 1000000 until the next frame_tick (cycle 17), then 0010000 from cycle 18.
REQ-025 digit2=4'hC -> anodes=1011 phase shows segments=0111111.
REQ-026 Reset asserted at cycle 7 for one cycle -> next edge anodes=1111 segments=1111111; LOAD then digit0 phase restarts.
REQ-027 LEADING_ZERO_BLANK_EN, inputs 0,0,0,5 -> digits 3,2,1 phases segments=1111111, digit0 phase 0010010; inputs 0,0,0,0 -> digit0 shows 1000000.
REQ-028 Over 10 frames with SCAN_DIV=4 -> frame_tick exactly every 16 cycles, anodes never zero-hot or multi-cold in SCAN.
